jedro_1_mini_core: RTL and testbench
====================================

// Module: jedro_1_mini_core
// PURPOSE
// - Minimal RV32I machine-mode core: fetches from a ROM port, executes a small instruction
//   subset, and owns a 32x32 register file plus a small CSR file.
// - Word loads/stores go through a byte-write RAM port.
// - Bring-up core for CSR instruction tests. Sits between instruction ROM and data RAM.
// - Stops on the first illegal instruction.
// PARAMETERS
// - DATA_WIDTH  32            data/instruction width; only 32 is supported
// - ADDR_WIDTH  32            byte address width of both memory ports
// - BOOT_ADDR   32'h0000_0000 PC value after reset
// PORTS
// - clk_i          in   1   single clock; all state updates on its rising edge
// - rst_i          in   1   synchronous, active-high reset
// - instr_addr_o   out  32  byte address of instruction fetch (always word aligned)
// - instr_en_o     out  1   fetch request
// - instr_rdata_i  in   32  instruction word, valid 1 cycle after the request
// - data_addr_o    out  32  data byte address (word aligned)
// - data_en_o      out  1   data access request
// - data_we_o      out  4   per-byte write enables; 4'b1111 on SW, 0 on LW
// - data_wdata_o   out  32  store data
// - data_rdata_i   in   32  load data, valid 1 cycle after the request
// - illegal_instr_o out 1   sticky: core has halted on an illegal instruction
// BEHAVIOUR
// - Reset (synchronous, active-high, clock-edge sampled):
//   - pc=BOOT_ADDR, state=FETCH, x1..x31=0, all CSRs=0.
//   - All outputs 0, except that instr_en_o and instr_addr_o show the first FETCH request
//     in the cycle after reset releases.
//   - Reset asserted mid-instruction aborts the instruction with no register, CSR or memory
//     side effect.
// - FSM:
//   - FETCH: drive instr_addr_o=pc and instr_en_o=1; next state EXEC.
//   - EXEC: decode instr_rdata_i and commit. LW issues its read and goes to LOAD.
//     Illegal goes to HALT. Every other instruction goes to FETCH.
//   - LOAD: write data_rdata_i to rd and goto FETCH.
//   - HALT: terminal until reset. pc, registers and CSRs are frozen; no memory requests.
// - Latency: 2 cycles per instruction; LW takes 3.
// - pc advances by 4 on commit; branch/jump targets replace pc+4.
// - Supported instructions:
//   - LUI, AUIPC, JAL, JALR (target bit0 cleared), BEQ, BNE.
//   - ADDI, ANDI, ORI, XORI, SLTI, ADD, SUB.
//   - LW, SW (word only).
//   - CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI.
//   - Any other opcode/funct combination is illegal.
// - Arithmetic: two's complement, 32-bit wrap. I/S/B immediates are sign-extended.
//   x0 always reads 0; writes to x0 are discarded.
// - Stores: data_addr_o=rs1+imm, data_we_o=4'b1111, data_en_o=1 for exactly the EXEC cycle.
// - CSRs and addresses:
//   - mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342: read/write, 32-bit.
//   - mhartid 0xF14: read-only, reads 0.
// - CSR access semantics:
//   - rd receives the old CSR value (skipped if rd=x0).
//   - The new CSR value uses the rs1 value, or zero-extended uimm[4:0] for the I forms.
//   - CSRRW/CSRRWI always write.
//   - CSRRS/CSRRC (and immediate forms) set/clear bits; they write only when rs1 index /
//     uimm is nonzero.
//   - Read and write in the same instruction is atomic: rd gets the pre-write value.
//   - rd==rs1: the CSR receives the old register value; rd receives the old CSR value.
// - Illegal instruction:
//   - Triggers: unknown CSR address, or any write to a read-only CSR.
//   - Effects: no register/CSR/memory update; illegal_instr_o=1 from the next cycle; state HALT.
//   - No trap is taken in this version.
// TESTING
// - Reset then ADDI x2,x0,0x55F; CSRRW x1,mscratch,x2 (mscratch=3) -> x1=3, mscratch=0x55F.
//   - mscratch is set to 3 beforehand by ADDI x3,x0,3; CSRRW x0,mscratch,x3.
// - Then CSRRW x0,mcause,x1 followed by all-zero word -> mcause=3, illegal_instr_o=1
//   within 2 cycles, pc frozen.
// - CSRRS x4,mscratch,x0 with mscratch=0x55F -> x4=0x55F, mscratch unchanged.
//   CSRRCI x5,mscratch,0x0F -> x5=0x55F, mscratch=0x550.
// - CSRRW x1,0xF14,x2 -> illegal, x1 unchanged.
//   CSRRW to address 0x7FF -> illegal, no write.
// - SW x2,8(x0) with x2=0x55F, then LW x6,8(x0) -> data_we_o=4'hF at addr 8; x6=0x55F.
// - Assert rst_i for 1 cycle mid-EXEC of ADDI x7,x0,5 -> x7=0, pc=BOOT_ADDR,
//   illegal_instr_o=0.

Source files
------------

// File: rtl/jedro_1_mini_core_if.sv
// Instruction-ROM and data-RAM port bundle for jedro_1_mini_core.
// Signal names match the original flat port list so the wiring above the core is unchanged.
interface jedro_1_mini_core_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] instr_addr_o;
    logic                  instr_en_o;
    logic [DATA_WIDTH-1:0] instr_rdata_i;
    logic [ADDR_WIDTH-1:0] data_addr_o;
    logic                  data_en_o;
    logic [3:0]            data_we_o;
    logic [DATA_WIDTH-1:0] data_wdata_o;
    logic [DATA_WIDTH-1:0] data_rdata_i;

    modport master (
        output instr_addr_o, instr_en_o,
        input  instr_rdata_i,
        output data_addr_o, data_en_o, data_we_o, data_wdata_o,
        input  data_rdata_i
    );

    modport slave (
        input  instr_addr_o, instr_en_o,
        output instr_rdata_i,
        input  data_addr_o, data_en_o, data_we_o, data_wdata_o,
        output data_rdata_i
    );
endinterface

// File: rtl/jedro_1_mini_core.sv
// Minimal RV32I machine-mode core for CSR bring-up: FETCH/EXEC(/LOAD) sequencing,
// 32x32 register file, small CSR file, halts on the first illegal instruction.
module jedro_1_mini_core #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    jedro_1_mini_core_if.master bus,
    output logic                illegal_instr_o
);
    typedef enum logic [1:0] {FETCH, EXEC, LOAD, HALT} state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rf [32];
    logic [DATA_WIDTH-1:0] mtvec, mscratch, mepc, mcause;
    logic [4:0]            load_rd;

    logic [31:0] instr;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

    assign instr    = bus.instr_rdata_i;
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7   = instr[31:25];
    assign csr_addr = instr[31:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

    // CSR read port and access-rights lookup
    logic                  csr_known, csr_ro;
    logic [DATA_WIDTH-1:0] csr_rdata;

    always_comb begin
        csr_known = 1'b1;
        csr_ro    = 1'b0;
        csr_rdata = '0;
        case (csr_addr)
            12'h305: csr_rdata = mtvec;
            12'h340: csr_rdata = mscratch;
            12'h341: csr_rdata = mepc;
            12'h342: csr_rdata = mcause;
            12'hF14: csr_ro    = 1'b1;
            default: csr_known = 1'b0;
        endcase
    end

    // Set/clear forms only write when the source index/uimm is nonzero
    logic                  csr_wr_req;
    logic [DATA_WIDTH-1:0] csr_src, csr_new;

    always_comb begin
        csr_src    = funct3[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1} : rs1_val;
        csr_wr_req = (funct3[1:0] == 2'b01) || (rs1 != 5'd0);
        case (funct3[1:0])
            2'b01:   csr_new = csr_src;
            2'b10:   csr_new = csr_rdata | csr_src;
            2'b11:   csr_new = csr_rdata & ~csr_src;
            default: csr_new = csr_rdata;
        endcase
    end

    logic                  legal, rd_we, is_load, is_store, csr_we;
    logic [DATA_WIDTH-1:0] rd_wdata;
    logic [ADDR_WIDTH-1:0] next_pc;

    always_comb begin
        legal    = 1'b0;
        rd_we    = 1'b0;
        rd_wdata = '0;
        next_pc  = pc + 4;
        is_load  = 1'b0;
        is_store = 1'b0;
        csr_we   = 1'b0;
        case (opcode)
            OP_LUI: begin
                legal = 1'b1; rd_we = 1'b1; rd_wdata = imm_u;
            end
            OP_AUIPC: begin
                legal = 1'b1; rd_we = 1'b1; rd_wdata = pc + imm_u;
            end
            OP_JAL: begin
                legal = 1'b1; rd_we = 1'b1; rd_wdata = pc + 4; next_pc = pc + imm_j;
            end
            OP_JALR: if (funct3 == 3'b000) begin
                legal = 1'b1; rd_we = 1'b1; rd_wdata = pc + 4;
                next_pc = (rs1_val + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000) begin
                    legal = 1'b1;
                    if (rs1_val == rs2_val) next_pc = pc + imm_b;
                end else if (funct3 == 3'b001) begin
                    legal = 1'b1;
                    if (rs1_val != rs2_val) next_pc = pc + imm_b;
                end
            end
            OP_IMM: begin
                legal = 1'b1;
                rd_we = 1'b1;
                case (funct3)
                    3'b000:  rd_wdata = rs1_val + imm_i;
                    3'b111:  rd_wdata = rs1_val & imm_i;
                    3'b110:  rd_wdata = rs1_val | imm_i;
                    3'b100:  rd_wdata = rs1_val ^ imm_i;
                    3'b010:  rd_wdata[0] = $signed(rs1_val) < $signed(imm_i);
                    default: begin legal = 1'b0; rd_we = 1'b0; end
                endcase
            end
            OP_REG: if (funct3 == 3'b000) begin
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1; rd_we = 1'b1; rd_wdata = rs1_val + rs2_val;
                end else if (funct7 == 7'b0100000) begin
                    legal = 1'b1; rd_we = 1'b1; rd_wdata = rs1_val - rs2_val;
                end
            end
            OP_LOAD:  if (funct3 == 3'b010) begin legal = 1'b1; is_load  = 1'b1; end
            OP_STORE: if (funct3 == 3'b010) begin legal = 1'b1; is_store = 1'b1; end
            OP_SYSTEM: begin
                if (funct3[1:0] != 2'b00 && csr_known && !(csr_ro && csr_wr_req)) begin
                    legal    = 1'b1;
                    rd_we    = 1'b1;
                    rd_wdata = csr_rdata;
                    csr_we   = csr_wr_req;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    // Requests are gated by rst_i so an aborted instruction never reaches memory
    logic mem_go;
    assign mem_go           = (state == EXEC) && legal && (is_load || is_store) && !rst_i;
    assign bus.instr_en_o   = (state == FETCH) && !rst_i;
    assign bus.instr_addr_o = bus.instr_en_o ? pc : '0;
    assign bus.data_en_o    = mem_go;
    assign bus.data_we_o    = (mem_go && is_store) ? 4'hF : 4'h0;
    assign bus.data_addr_o  = mem_go ? rs1_val + (is_store ? imm_s : imm_i) : '0;
    assign bus.data_wdata_o = (mem_go && is_store) ? rs2_val : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= FETCH;
            pc              <= BOOT_ADDR;
            illegal_instr_o <= 1'b0;
            load_rd         <= '0;
            mtvec           <= '0;
            mscratch        <= '0;
            mepc            <= '0;
            mcause          <= '0;
            for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                FETCH: state <= EXEC;
                EXEC: begin
                    if (!legal) begin
                        state           <= HALT;
                        illegal_instr_o <= 1'b1;
                    end else begin
                        pc <= next_pc;
                        if (rd_we && rd != 5'd0) rf[rd] <= rd_wdata;
                        if (csr_we) begin
                            case (csr_addr)
                                12'h305: mtvec    <= csr_new;
                                12'h340: mscratch <= csr_new;
                                12'h341: mepc     <= csr_new;
                                12'h342: mcause   <= csr_new;
                                default: ;
                            endcase
                        end
                        if (is_load) begin
                            load_rd <= rd;
                            state   <= LOAD;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                LOAD: begin
                    if (load_rd != 5'd0) rf[load_rd] <= bus.data_rdata_i;
                    state <= FETCH;
                end
                HALT: state <= HALT;
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_jedro_1_mini_core.sv
// Scoreboarded bench for jedro_1_mini_core: directed programs in a ROM model, every
// store observed on the data port is matched against hand-computed expectations.
module tb_jedro_1_mini_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic illegal;

    always #5 clk = ~clk;

    jedro_1_mini_core_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    jedro_1_mini_core #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BOOT_ADDR(32'h0)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus),
        .illegal_instr_o(illegal)
    );

    logic [31:0] rom [256];
    logic [31:0] ram [64];
    int unsigned wp;

    always @(posedge clk) begin
        if (bus.instr_en_o) bus.instr_rdata_i <= rom[bus.instr_addr_o[9:2]];
        if (bus.data_en_o) begin
            if (bus.data_we_o == 4'hF) ram[bus.data_addr_o[7:2]] <= bus.data_wdata_o;
            bus.data_rdata_i <= ram[bus.data_addr_o[7:2]];
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;
    st_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Store monitor: pops one expectation per observed write
    always @(negedge clk) begin
        if (bus.data_en_o && bus.data_we_o != 4'h0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_store: got addr %h data %h, expected no store",
                         bus.data_addr_o, bus.data_wdata_o);
            end else begin
                st_t e;
                e = exp_q.pop_front();
                chk("st_addr", bus.data_addr_o, e.addr);
                chk("st_data", bus.data_wdata_o, e.data);
                chk("st_we", 32'(bus.data_we_o), 32'hF);
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] opi(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
        return enc_i(imm, rs1, f3, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] csr(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] a);
        return enc_i(a, rs1, f3, rd, 7'b1110011);
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] off);
        return enc_i(off, rs1, 3'b010, rd, 7'b0000011);
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [11:0] off);
        return {off[11:5], rs2, rs1, 3'b010, off[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] rr(input logic [6:0] f7, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [12:0] b);
        return {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] j);
        return {j[20], j[10:1], j[11], j[19:12], rd, 7'b1101111};
    endfunction

    task automatic emit(input logic [31:0] w);
        rom[wp] = w;
        wp++;
    endtask
    task automatic exp_st(input logic [31:0] a, input logic [31:0] d);
        st_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic begin_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        wp = 0;
    endtask

    task automatic end_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl_outputs", {28'h0, bus.instr_en_o, bus.data_en_o, illegal, |bus.data_we_o}, 32'h0);
        chk("rst_addr_outputs", bus.instr_addr_o | bus.data_addr_o | bus.data_wdata_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_fetch_en", 32'(bus.instr_en_o), 32'h1);
        chk("rst_fetch_addr", bus.instr_addr_o, 32'h0);
    endtask

    task automatic wait_halt(input logic [31:0] haddr);
        int unsigned cyc = 0;
        int unsigned lat = 0;
        int unsigned busy = 0;
        bit seen = 1'b0;
        while (!illegal && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (seen) lat++;
            else if (bus.instr_en_o && bus.instr_addr_o == haddr) seen = 1'b1;
        end
        chk("halt_reached", 32'(illegal), 32'h1);
        chk("halt_latency", lat, 32'd2);
        repeat (4) begin
            @(negedge clk);
            if (bus.instr_en_o || bus.data_en_o) busy++;
        end
        chk("halt_quiet", busy, 32'd0);
        chk("pc_frozen", dut.pc, haddr);
        chk("illegal_sticky", 32'(illegal), 32'h1);
        chk("stores_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Program 1: CSR semantics, load/store, ALU, control flow, then an all-zero word
        begin_reset();
        emit(opi(3'b000, 5'd3, 5'd0, 12'd3));            // 0   addi x3,x0,3
        emit(csr(3'b001, 5'd0, 5'd3, 12'h340));          // 4   csrrw x0,mscratch,x3
        emit(opi(3'b000, 5'd2, 5'd0, 12'h55F));          // 8   addi x2,x0,0x55f
        emit(csr(3'b001, 5'd1, 5'd2, 12'h340));          // 12  csrrw x1,mscratch,x2
        emit(sw(5'd1, 5'd0, 12'd0));   exp_st(32'd0, 32'd3);
        emit(csr(3'b010, 5'd4, 5'd0, 12'h340));          // 20  csrrs x4,mscratch,x0
        emit(sw(5'd4, 5'd0, 12'd4));   exp_st(32'd4, 32'h55F);
        emit(csr(3'b111, 5'd5, 5'd15, 12'h340));         // 28  csrrci x5,mscratch,15
        emit(sw(5'd5, 5'd0, 12'd12));  exp_st(32'd12, 32'h55F);
        emit(csr(3'b010, 5'd6, 5'd0, 12'h340));          // 36
        emit(sw(5'd6, 5'd0, 12'd16));  exp_st(32'd16, 32'h550);
        emit(sw(5'd2, 5'd0, 12'd8));   exp_st(32'd8, 32'h55F);
        emit(lw(5'd7, 5'd0, 12'd8));                     // 48
        emit(sw(5'd7, 5'd0, 12'd20));  exp_st(32'd20, 32'h55F);
        emit(csr(3'b101, 5'd8, 5'd31, 12'h305));         // 56  csrrwi x8,mtvec,31
        emit(csr(3'b110, 5'd9, 5'd0, 12'h305));          // 60  csrrsi x9,mtvec,0
        emit(sw(5'd9, 5'd0, 12'd24));  exp_st(32'd24, 32'd31);
        emit(sw(5'd8, 5'd0, 12'd28));  exp_st(32'd28, 32'd0);
        emit(csr(3'b011, 5'd10, 5'd3, 12'h305));         // 72  csrrc x10,mtvec,x3
        emit(csr(3'b010, 5'd11, 5'd0, 12'h305));         // 76
        emit(sw(5'd10, 5'd0, 12'd32)); exp_st(32'd32, 32'd31);
        emit(sw(5'd11, 5'd0, 12'd36)); exp_st(32'd36, 32'd28);
        emit(opi(3'b000, 5'd12, 5'd0, 12'd7));           // 88
        emit(csr(3'b010, 5'd12, 5'd0, 12'hF14));         // 92  csrrs x12,mhartid,x0
        emit(sw(5'd12, 5'd0, 12'd40)); exp_st(32'd40, 32'd0);
        emit(csr(3'b001, 5'd3, 5'd3, 12'h341));          // 100 csrrw x3,mepc,x3
        emit(csr(3'b010, 5'd13, 5'd0, 12'h341));         // 104
        emit(sw(5'd3, 5'd0, 12'd44));  exp_st(32'd44, 32'd0);
        emit(sw(5'd13, 5'd0, 12'd48)); exp_st(32'd48, 32'd3);
        emit(opi(3'b000, 5'd3, 5'd0, 12'd3));            // 116
        emit(opi(3'b000, 5'd14, 5'd0, 12'hFFF));         // 120 addi x14,x0,-1
        emit(opi(3'b010, 5'd15, 5'd14, 12'd0));          // 124 slti x15,x14,0
        emit(rr(7'b0000000, 5'd16, 5'd14, 5'd3));        // 128 add
        emit(rr(7'b0100000, 5'd17, 5'd3, 5'd14));        // 132 sub
        emit(opi(3'b100, 5'd18, 5'd2, 12'h0FF));         // 136 xori
        emit(opi(3'b111, 5'd19, 5'd2, 12'h0F0));         // 140 andi
        emit(opi(3'b110, 5'd20, 5'd3, 12'h100));         // 144 ori
        emit({20'h12345, 5'd21, 7'b0110111});            // 148 lui
        emit({20'h00001, 5'd22, 7'b0010111});            // 152 auipc
        emit(sw(5'd15, 5'd0, 12'd52)); exp_st(32'd52, 32'd1);
        emit(sw(5'd16, 5'd0, 12'd56)); exp_st(32'd56, 32'd2);
        emit(sw(5'd17, 5'd0, 12'd60)); exp_st(32'd60, 32'd4);
        emit(sw(5'd18, 5'd0, 12'd64)); exp_st(32'd64, 32'h5A0);
        emit(sw(5'd19, 5'd0, 12'd68)); exp_st(32'd68, 32'h050);
        emit(sw(5'd20, 5'd0, 12'd72)); exp_st(32'd72, 32'h103);
        emit(sw(5'd21, 5'd0, 12'd76)); exp_st(32'd76, 32'h12345000);
        emit(sw(5'd22, 5'd0, 12'd80)); exp_st(32'd80, 32'h1098);
        emit(sw(5'd14, 5'd0, 12'd84)); exp_st(32'd84, 32'hFFFF_FFFF);
        emit(br(3'b000, 5'd3, 5'd16, 13'd8));            // 192 beq not taken
        emit(br(3'b001, 5'd3, 5'd16, 13'd8));            // 196 bne taken -> 204
        emit(sw(5'd3, 5'd0, 12'd88));                    // 200 skipped
        emit(jal(5'd23, 21'd8));                         // 204 jal -> 212
        emit(sw(5'd3, 5'd0, 12'd92));                    // 208 skipped
        emit(sw(5'd23, 5'd0, 12'd96)); exp_st(32'd96, 32'd208);
        emit(opi(3'b000, 5'd24, 5'd0, 12'd233));         // 216
        emit(enc_i(12'd0, 5'd24, 3'b000, 5'd25, 7'b1100111)); // 220 jalr -> 232
        emit(sw(5'd3, 5'd0, 12'd100));                   // 224 skipped
        emit(sw(5'd3, 5'd0, 12'd104));                   // 228 skipped
        emit(sw(5'd25, 5'd0, 12'd108)); exp_st(32'd108, 32'd224);
        emit(br(3'b000, 5'd3, 5'd3, 13'd8));             // 236 beq taken -> 244
        emit(sw(5'd3, 5'd0, 12'd112));                   // 240 skipped
        emit(csr(3'b001, 5'd0, 5'd1, 12'h342));          // 244 csrrw x0,mcause,x1
        emit(csr(3'b010, 5'd26, 5'd0, 12'h342));         // 248
        emit(sw(5'd26, 5'd0, 12'd116)); exp_st(32'd116, 32'd3);
        emit(opi(3'b000, 5'd0, 5'd0, 12'd5));            // 256 addi x0,x0,5
        emit(sw(5'd0, 5'd0, 12'd120));  exp_st(32'd120, 32'd0);
        emit(rr(7'b0100000, 5'd27, 5'd0, 5'd3));         // 264 sub x27,x0,x3
        emit(sw(5'd27, 5'd0, 12'd124)); exp_st(32'd124, 32'hFFFF_FFFD);
        emit(32'h0000_0000);                             // 272 illegal
        emit(sw(5'd3, 5'd0, 12'd128));                   // 276 never reached
        end_reset();
        wait_halt(32'd272);

        // Program 2: write to read-only mhartid halts and leaves rd untouched
        begin_reset();
        emit(opi(3'b000, 5'd1, 5'd0, 12'd9));
        emit(opi(3'b000, 5'd2, 5'd0, 12'h55F));
        emit(sw(5'd1, 5'd0, 12'd0)); exp_st(32'd0, 32'd9);
        emit(csr(3'b001, 5'd1, 5'd2, 12'hF14));          // 12 illegal
        end_reset();
        wait_halt(32'd12);
        chk("ro_csr_x1_kept", dut.rf[1], 32'd9);

        // Program 3: unknown CSR address
        begin_reset();
        emit(opi(3'b000, 5'd2, 5'd0, 12'h55F));
        emit(csr(3'b001, 5'd0, 5'd2, 12'h7FF));          // 4 illegal
        end_reset();
        wait_halt(32'd4);

        // Program 4: CSRRS to mhartid with nonzero rs1 is a write, hence illegal
        begin_reset();
        emit(opi(3'b000, 5'd2, 5'd0, 12'h55F));
        emit(opi(3'b000, 5'd1, 5'd0, 12'd9));
        emit(csr(3'b010, 5'd1, 5'd2, 12'hF14));          // 8 illegal
        end_reset();
        wait_halt(32'd8);
        chk("ro_set_x1_kept", dut.rf[1], 32'd9);

        // Program 5: reset during EXEC of addi x7 aborts it
        begin_reset();
        emit(opi(3'b000, 5'd7, 5'd0, 12'd5));
        emit(sw(5'd7, 5'd0, 12'd0)); exp_st(32'd0, 32'd5);
        emit(32'h0000_0000);                             // 8 illegal
        end_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midexec_x7", dut.rf[7], 32'd0);
        chk("midexec_pc", dut.pc, 32'd0);
        chk("midexec_fetch", {31'd0, bus.instr_en_o}, 32'd1);
        chk("midexec_illegal", 32'(illegal), 32'd0);
        wait_halt(32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
